demux_chan_sched: RTL and testbench

//  Upstream feeder for the 1:4 structural demux: accepts 1-bit symbols over a

---
 rtl/demux_pkg.sv | 26 ++
 rtl/demux_rr_pick.sv | 33 +++
 rtl/demux_chan_sched.sv | 138 +++++++++++++
 tb/tb_demux_chan_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the demux channel scheduler: channel count, select width,
// FSM state encodings and the frame-completion helper.
`default_nettype none

package demux_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // True when no channel numbered above sel is enabled, i.e. sel closes the frame.
  function automatic logic none_above(input logic [NCH-1:0] mask,
                                      input logic [SEL_W-1:0] sel);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if ((i > int'(sel)) && mask[i]) hit = 1'b1;
    end
    return !hit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_rr_pick.sv
// Round-robin picker: first enabled channel at or after ptr, wrapping past the
// top channel back to channel 0.
`default_nettype none

module demux_rr_pick
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] ptr,
  input  logic [NCH-1:0]   mask,
  output logic [SEL_W-1:0] sel,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    any   = |mask;
    for (int k = 0; k < NCH; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && mask[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_chan_sched.sv
// Feeds the 1:4 demux: accepts symbols, picks a channel round-robin and holds d/s
// for HOLD_CYC cycles. Per-channel delivery counters built under DEMUX_SCHED_CNT_EN.
`default_nettype none

module demux_chan_sched
  import demux_pkg::*;
#(
  parameter int HOLD_CYC = 2,
  parameter int CNT_W    = 8
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_data,
  output logic               in_ready,
  input  logic [NCH-1:0]     chan_mask,
  output logic               d,
  output logic [SEL_W-1:0]   s,
  output logic               strobe,
  output logic               frame_done,
  output logic [NCH*CNT_W-1:0] chan_cnt
);

  localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HC_W-1:0] HC_LOAD = HC_W'(HOLD_CYC - 1);

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic             d_q, d_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic             strobe_q, strobe_d;
  logic             frame_done_q, frame_done_d;

  logic [SEL_W-1:0] pick_sel;
  logic             pick_any;
  logic             accept;
  logic             hold_done;

  demux_rr_pick u_pick (
    .ptr  (ptr_q),
    .mask (chan_mask),
    .sel  (pick_sel),
    .any  (pick_any)
  );

  assign in_ready  = (state_q == ST_IDLE) && pick_any && !rst;
  assign accept    = in_valid && in_ready;
  assign hold_done = (hold_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_HOLD;
      ST_HOLD: if (hold_done) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d        = ptr_q;
    hold_cnt_d   = hold_cnt_q;
    d_d          = d_q;
    s_d          = s_q;
    strobe_d     = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          d_d        = in_data;
          s_d        = pick_sel;
          hold_cnt_d = HC_LOAD;
          strobe_d   = 1'b1;
        end else begin
          d_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (hold_done) begin
          d_d          = 1'b0;
          ptr_d        = s_q + SEL_W'(1);
          frame_done_d = none_above(chan_mask, s_q);
        end else begin
          hold_cnt_d = hold_cnt_q - HC_W'(1);
        end
      end
      default: d_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      hold_cnt_q   <= '0;
      d_q          <= 1'b0;
      s_q          <= '0;
      strobe_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      d_q          <= d_d;
      s_q          <= s_d;
      strobe_q     <= strobe_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign d          = d_q;
  assign s          = s_q;
  assign strobe     = strobe_q;
  assign frame_done = frame_done_q;

`ifdef DEMUX_SCHED_CNT_EN
  // Saturating counters: a channel pinned for a long run stops at all-ones.
  for (genvar i = 0; i < NCH; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (accept && (pick_sel == SEL_W'(i)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
    assign chan_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`else
  assign chan_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_chan_sched.sv
// Self-checking bench for demux_chan_sched: scoreboard of expected d/s/frame_done
// per symbol, plus reset, empty-mask, reset-during-hold and counter scenarios.
`default_nettype none

module tb_demux_chan_sched;

  localparam int HOLD_CYC = 2;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_data;
  logic             in_ready;
  logic [3:0]       chan_mask;
  logic             d;
  logic [1:0]       s;
  logic             strobe;
  logic             frame_done;
  logic [4*CNT_W-1:0] chan_cnt;

  typedef struct {
    logic       d;
    logic [1:0] s;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  demux_chan_sched #(.HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .chan_mask  (chan_mask),
    .d          (d),
    .s          (s),
    .strobe     (strobe),
    .frame_done (frame_done),
    .chan_cnt   (chan_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; chan_mask = 4'hF;
    @(negedge clk);
    tests_run++;
    if (d !== 1'b0 || s !== 2'd0 || strobe !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: d=%b s=%0d strobe=%b fd=%b, required all 0", d, s, strobe, frame_done);
    end
    tests_run++;
    if (chan_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_cnt: chan_cnt=%h, required 0", chan_cnt);
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: in_ready=%b during rst, required 0", in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_after: in_ready=%b, required 1", in_ready);
    end
  endtask

  // Sends n symbols; expected d/s/frame_done per symbol come from the caller's tables.
  task automatic test_sequence(input string name, input logic [3:0] mask, input int n,
                               input logic [3:0] data_v, input logic [7:0] s_v,
                               input logic [3:0] fd_v);
    exp_t e;
    int   w;
    chan_mask = mask;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s_ready[%0d]: in_ready=%b, required 1 within 20 cycles", name, i, in_ready);
      end
      in_valid = 1'b1; in_data = data_v[i];
      sb.push_back('{d: data_v[i], s: s_v[2*i +: 2], fd: fd_v[i]});
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL %s_sb[%0d]: scoreboard empty, required 1 entry", name, i);
        continue;
      end
      e = sb.pop_front();
      if (d !== e.d || s !== e.s || strobe !== 1'b1 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_first[%0d]: d=%b s=%0d strobe=%b rdy=%b, required d=%b s=%0d strobe=1 rdy=0",
                 name, i, d, s, strobe, in_ready, e.d, e.s);
      end
      for (int k = 1; k < HOLD_CYC; k++) begin
        @(negedge clk);
        tests_run++;
        if (d !== e.d || s !== e.s || strobe !== 1'b0 || frame_done !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s_hold[%0d]: d=%b s=%0d strobe=%b fd=%b, required d=%b s=%0d strobe=0 fd=0",
                   name, i, d, s, strobe, frame_done, e.d, e.s);
        end
      end
      @(negedge clk);
      tests_run++;
      if (frame_done !== e.fd || d !== 1'b0 || strobe !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_exit[%0d]: fd=%b d=%b strobe=%b, required fd=%b d=0 strobe=0",
                 name, i, frame_done, d, strobe, e.fd);
      end
    end
  endtask

  task automatic test_empty_mask();
    chan_mask = 4'h0; in_valid = 1'b1; in_data = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || strobe !== 1'b0 || d !== 1'b0) begin
        tests_failed++;
        $display("FAIL empty_mask[%0d]: rdy=%b strobe=%b d=%b, required all 0", i, in_ready, strobe, d);
      end
    end
    in_valid = 1'b0; in_data = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    // ch0 first so ptr=1, then a ch1 symbol is cut by reset at its exit edge.
    test_sequence("rst_pre", 4'hF, 1, 4'b0001, 8'h00, 4'b0000);
    @(negedge clk);
    in_valid = 1'b1; in_data = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (s !== 2'd1 || d !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_hold_pre: s=%0d d=%b, required s=1 d=1", s, d);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (d !== 1'b0 || s !== 2'd0 || strobe !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_hold: d=%b s=%0d strobe=%b fd=%b rdy=%b, required all 0",
               d, s, strobe, frame_done, in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    test_sequence("rst_post", 4'hF, 1, 4'b0001, 8'h00, 4'b0000);
  endtask

  task automatic test_counters();
    int w;
    int exp_cnt;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chan_mask = 4'b0001;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      if (in_ready !== 1'b1) begin
        tests_run++; tests_failed++;
        $display("FAIL cnt_ready[%0d]: in_ready=%b, required 1 within 20 cycles", k, in_ready);
      end
      in_valid = 1'b1; in_data = k[0];
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
`ifdef DEMUX_SCHED_CNT_EN
      exp_cnt = (k > 255) ? 255 : k;
`else
      exp_cnt = 0;
`endif
      if (k % 50 == 0 || k >= 254) begin
        tests_run++;
        if (chan_cnt[CNT_W-1:0] !== CNT_W'(exp_cnt) || chan_cnt[4*CNT_W-1:CNT_W] !== '0) begin
          tests_failed++;
          $display("FAIL cnt[%0d]: chan_cnt=%h, required ch0=%0d others 0", k, chan_cnt, exp_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence("rr_full", 4'hF, 4, 4'b1101, 8'b11_10_01_00, 4'b1000);
    test_sequence("rr_sparse", 4'b1010, 4, 4'b0110, 8'b11_01_11_01, 4'b1010);
    test_empty_mask();
    test_reset_in_hold();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
